spi_ram_arbiter: RTL and testbench
==================================

// Module: spi_ram_arbiter
// PURPOSE
//  Sequences and shares the single-port RAM between the SPI slave command stream and a local host port.
//  Decodes 10-bit SPI frames (addr/data commands) and holds the SPI write/read address registers.
//  Drives the RAM port and returns SPI read data as tx_valid/tx_data.
//  Sits between the SPI slave, the RAM and the host, replacing the direct SPI-to-RAM connection.
// PARAMETERS
//  ADDR_W  8  RAM address width; must be <= DATA_W (SPI address is taken from rx_data[ADDR_W-1:0])
//  DATA_W  8  RAM data width; rx_data width is DATA_W+2
// PORTS
//  clk          in   1          system clock
//  rst          in   1          synchronous reset, active-high
//  rx_valid     in   1          SPI frame strobe, 1 cycle, no backpressure
//  rx_data      in   DATA_W+2   [9:8] cmd: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA
//  tx_valid     out  1          1-cycle pulse, SPI read data valid
//  tx_data      out  DATA_W     SPI read data, held until next tx_valid
//  host_req     in   1          host access request, held with fields until host_ack
//  host_we      in   1          1 = write, 0 = read
//  host_addr    in   ADDR_W     host address
//  host_wdata   in   DATA_W     host write data
//  host_ack     out  1          1-cycle pulse, request accepted (issued to RAM this cycle)
//  host_rvalid  out  1          1-cycle pulse, host read data valid
//  host_rdata   out  DATA_W     host read data, held until next host_rvalid
//  ram_en       out  1          RAM access strobe
//  ram_we       out  1          RAM write enable (qualified by ram_en)
//  ram_addr     out  ADDR_W     RAM address
//  ram_wdata    out  DATA_W     RAM write data
//  ram_rdata    in   DATA_W     RAM read data, valid the cycle after ram_en & !ram_we
//  spi_ovf      out  1          sticky: SPI data frame dropped; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; wr_addr=rd_addr=0; pending buffer empty; FSM IDLE; in-flight read dropped.
//  SPI capture (every cycle, independent of FSM):
//   WR_ADDR/RD_ADDR: load wr_addr/rd_addr from rx_data[ADDR_W-1:0] next edge; no RAM access.
//   WR_DATA/RD_DATA: load 1-entry pending buffer (cmd + data). Buffer full on arrival -> frame
//    dropped, spi_ovf<=1. Slot freed in the cycle the SPI access issues; a frame arriving that
//    same cycle is accepted.
//   RD_DATA payload ignored. Address frames never set spi_ovf.
//  FSM: IDLE -> ACCESS -> (read) RESP -> IDLE; (write) ACCESS -> IDLE.
//   IDLE: grant from registered state: pending buffer full -> SPI; else host_req -> host; else stay.
//    Pending buffer sees a new frame one cycle after rx_valid (host wins a same-cycle tie).
//   ACCESS (1 cycle): ram_en=1; SPI write: addr=wr_addr, wdata=buffer; SPI read: addr=rd_addr;
//    host: host_we/addr/wdata, host_ack=1. Outside ACCESS ram_en=ram_we=0.
//   RESP (1 cycle): ram_rdata -> tx_data + tx_valid (SPI) or host_rdata + host_rvalid (host).
//  Latency: write 1 cycle after grant; read data 2 cycles after grant. Max 1 access in flight.
//  Host may drop host_req before ack; no access issues. rst mid-ACCESS/RESP: no pulse output.
// CONFIGURATION
//  SPI_ADDR_AUTOINC_EN defined: wr_addr += 1 after each SPI write issues, rd_addr += 1 after each
//   SPI read issues, both mod 2^ADDR_W (0xFF wraps to 0x00). A same-cycle WR_ADDR/RD_ADDR load wins.
//  Not defined: wr_addr/rd_addr change only on address frames.
// STRUCTURE
//  Package spi_ram_pkg: cmd localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10,
//   CMD_RD_DATA=2'b11; FSM state typedef {IDLE, ACCESS, RESP}; grant-owner typedef {OWN_SPI, OWN_HOST}.
//  Sub-module spi_cmd_capture: frame decode, address registers, pending buffer, spi_ovf, autoinc.
//  Top: arbitration FSM, RAM mux and response routing.
// TESTING
//  1 SPI WR_ADDR 0x10, WR_DATA 0xA5 -> ram_en&ram_we, addr 0x10, wdata 0xA5 one cycle after grant.
//  2 SPI RD_ADDR 0x10, RD_DATA -> tx_valid pulse, tx_data 0xA5, 2 cycles after grant; no host pulses.
//  3 host_req read 0x20 in the same cycle as an SPI WR_DATA rx_valid -> host granted first
//    (host_ack), SPI write issues right after RESP; no spi_ovf.
//  4 Host read in flight, two WR_DATA frames back-to-back -> first frame buffered and written,
//    second dropped, spi_ovf=1 and stays 1 until rst.
//  5 rst asserted during RESP of a host read -> no host_rvalid; all outputs 0 next cycle; addr regs 0.
//  6 SPI_ADDR_AUTOINC_EN: WR_ADDR 0xFF, WR_DATA x2 -> writes at 0xFF then 0x00; without macro both 0xFF.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared command codes, FSM state and grant-owner types for the SPI/host RAM arbiter.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_SPI  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // Data frames (WR_DATA / RD_DATA) are the odd command codes.
    function automatic logic is_data_cmd(input logic [1:0] cmd);
        return cmd[0];
    endfunction

endpackage

// File: rtl/spi_cmd_capture.sv
// SPI frame decode: address registers, 1-entry pending command buffer and sticky overflow flag.
// Optional SPI_ADDR_AUTOINC_EN: advance wr/rd address after each SPI data access issues.
module spi_cmd_capture
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_rx_valid,
    input  logic [DATA_W+1:0] i_rx_data,
    input  logic              i_spi_issue,
    output logic [ADDR_W-1:0] o_wr_addr_nxt,
    output logic [ADDR_W-1:0] o_rd_addr_nxt,
    output logic              o_pend_valid,
    output logic              o_pend_is_rd,
    output logic [DATA_W-1:0] o_pend_data,
    output logic              o_spi_ovf
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_pend_valid;
    logic              r_pend_is_rd;
    logic [DATA_W-1:0] r_pend_data;
    logic              r_spi_ovf;

    logic [1:0]        w_cmd;
    logic              w_ld_wr;
    logic              w_ld_rd;
    logic              w_data_frame;
    logic              w_inc_wr;
    logic              w_inc_rd;
    logic [ADDR_W-1:0] w_wr_nxt;
    logic [ADDR_W-1:0] w_rd_nxt;

    assign w_cmd        = i_rx_data[DATA_W+1:DATA_W];
    assign w_ld_wr      = i_rx_valid && (w_cmd == CMD_WR_ADDR);
    assign w_ld_rd      = i_rx_valid && (w_cmd == CMD_RD_ADDR);
    assign w_data_frame = i_rx_valid && is_data_cmd(w_cmd);

`ifdef SPI_ADDR_AUTOINC_EN
    assign w_inc_wr = i_spi_issue && r_pend_valid && !r_pend_is_rd;
    assign w_inc_rd = i_spi_issue && r_pend_valid &&  r_pend_is_rd;
`else
    assign w_inc_wr = 1'b0;
    assign w_inc_rd = 1'b0;
`endif

    // An address frame in the same cycle as an increment takes priority.
    assign w_wr_nxt = w_ld_wr  ? i_rx_data[ADDR_W-1:0] :
                      w_inc_wr ? (r_wr_addr + ADDR_ONE) : r_wr_addr;
    assign w_rd_nxt = w_ld_rd  ? i_rx_data[ADDR_W-1:0] :
                      w_inc_rd ? (r_rd_addr + ADDR_ONE) : r_rd_addr;

    // Address registers, pending buffer and overflow flag.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_addr    <= {ADDR_W{1'b0}};
            r_rd_addr    <= {ADDR_W{1'b0}};
            r_pend_valid <= 1'b0;
            r_pend_is_rd <= 1'b0;
            r_pend_data  <= {DATA_W{1'b0}};
            r_spi_ovf    <= 1'b0;
        end else begin
            r_wr_addr <= w_wr_nxt;
            r_rd_addr <= w_rd_nxt;
            if (w_data_frame) begin
                if (r_pend_valid && !i_spi_issue) begin
                    r_spi_ovf <= 1'b1;
                end else begin
                    r_pend_valid <= 1'b1;
                    r_pend_is_rd <= w_cmd[1];
                    r_pend_data  <= i_rx_data[DATA_W-1:0];
                end
            end else if (i_spi_issue) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign o_wr_addr_nxt = w_wr_nxt;
    assign o_rd_addr_nxt = w_rd_nxt;
    assign o_pend_valid  = r_pend_valid;
    assign o_pend_is_rd  = r_pend_is_rd;
    assign o_pend_data   = r_pend_data;
    assign o_spi_ovf     = r_spi_ovf;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares a single-port RAM between the SPI command stream and a local host port.
// Optional SPI_ADDR_AUTOINC_EN (in spi_cmd_capture): SPI addresses auto-increment per access.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W+1:0] rx_data,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              spi_ovf
);

    state_t            r_state;
    owner_t            r_owner;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_host_ack;
    logic              r_tx_valid;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_host_rdata;

    logic              w_spi_issue;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic [ADDR_W-1:0] w_rd_addr_nxt;
    logic              w_pend_valid;
    logic              w_pend_is_rd;
    logic [DATA_W-1:0] w_pend_data;

    assign w_spi_issue = (r_state == ACCESS) && (r_owner == OWN_SPI);

    spi_cmd_capture #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_capture (
        .clk           (clk),
        .i_rst         (rst),
        .i_rx_valid    (rx_valid),
        .i_rx_data     (rx_data),
        .i_spi_issue   (w_spi_issue),
        .o_wr_addr_nxt (w_wr_addr_nxt),
        .o_rd_addr_nxt (w_rd_addr_nxt),
        .o_pend_valid  (w_pend_valid),
        .o_pend_is_rd  (w_pend_is_rd),
        .o_pend_data   (w_pend_data),
        .o_spi_ovf     (spi_ovf)
    );

    // Arbitration FSM with registered RAM port and response strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= OWN_SPI;
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= {ADDR_W{1'b0}};
            r_ram_wdata   <= {DATA_W{1'b0}};
            r_host_ack    <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= {DATA_W{1'b0}};
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= {DATA_W{1'b0}};
        end else begin
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_host_ack    <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_host_rvalid <= 1'b0;
            if (r_tx_valid) begin
                r_tx_data <= ram_rdata;
            end
            if (r_host_rvalid) begin
                r_host_rdata <= ram_rdata;
            end
            case (r_state)
                IDLE: begin
                    if (w_pend_valid) begin
                        r_state     <= ACCESS;
                        r_owner     <= OWN_SPI;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= !w_pend_is_rd;
                        r_ram_addr  <= w_pend_is_rd ? w_rd_addr_nxt : w_wr_addr_nxt;
                        r_ram_wdata <= w_pend_data;
                    end else if (host_req) begin
                        r_state     <= ACCESS;
                        r_owner     <= OWN_HOST;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= host_we;
                        r_ram_addr  <= host_addr;
                        r_ram_wdata <= host_wdata;
                        r_host_ack  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (r_ram_we) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= RESP;
                        if (r_owner == OWN_SPI) begin
                            r_tx_valid <= 1'b1;
                        end else begin
                            r_host_rvalid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign host_ack  = r_host_ack;

    // Read data is passed through in RESP and held afterwards; a reset in RESP kills the pulse.
    assign tx_valid    = r_tx_valid && !rst;
    assign tx_data     = r_tx_valid ? ram_rdata : r_tx_data;
    assign host_rvalid = r_host_rvalid && !rst;
    assign host_rdata  = r_host_rvalid ? ram_rdata : r_host_rdata;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Randomized self-checking bench for spi_ram_arbiter against a transaction-level memory model.
module tb_spi_ram_arbiter;
    import spi_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [9:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       spi_ovf;

    logic [7:0] mem   [0:255];
    logic [7:0] m_mem [0:255];
    logic [7:0] m_wr;
    logic [7:0] m_rd;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .spi_ovf(spi_ovf)
    );

    // Synchronous single-port RAM: read data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return ram_en && ram_we;
            1:       return tx_valid;
            2:       return host_ack;
            default: return host_rvalid;
        endcase
    endfunction

    task automatic wait_sig(input int sel, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sig(sel) && n < 20);
    endtask

    function automatic logic [63:0] all_outs();
        return {26'd0, tx_valid, tx_data, host_ack, host_rvalid, host_rdata,
                ram_en, ram_we, ram_addr, ram_wdata, spi_ovf};
    endfunction

    task automatic bump_wr();
`ifdef SPI_ADDR_AUTOINC_EN
        m_wr = m_wr + 8'd1;
`endif
    endtask

    task automatic bump_rd();
`ifdef SPI_ADDR_AUTOINC_EN
        m_rd = m_rd + 8'd1;
`endif
    endtask

    task automatic send(input logic [1:0] cmd, input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = {cmd, d};
    endtask

    task automatic spi_addr(input logic [1:0] cmd, input logic [7:0] a);
        send(cmd, a);
        tick();
        if (cmd == CMD_WR_ADDR) m_wr = a;
        else                    m_rd = a;
    endtask

    task automatic spi_write(input logic [7:0] d);
        int n;
        send(CMD_WR_DATA, d);
        wait_sig(0, n);
        check_eq("spi_wr_lat", n, 2);
        check_eq("spi_wr_port", {ram_addr, ram_wdata}, {m_wr, d});
        m_mem[m_wr] = d;
        bump_wr();
        tick();
    endtask

    task automatic spi_read();
        int n;
        logic [7:0] e;
        e = m_mem[m_rd];
        send(CMD_RD_DATA, 8'($urandom));
        wait_sig(1, n);
        check_eq("spi_rd_lat", n, 3);
        check_eq("spi_rd_data", {host_rvalid, tx_data}, {1'b0, e});
        bump_rd();
        tick();
        check_eq("spi_rd_hold", {tx_valid, tx_data}, {1'b0, e});
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        int n;
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        wait_sig(2, n);
        check_eq("host_wr_lat", n, 1);
        check_eq("host_wr_port", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, a, d});
        host_req = 1'b0;
        m_mem[a] = d;
        tick();
    endtask

    task automatic host_read(input logic [7:0] a);
        int n;
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        wait_sig(2, n);
        check_eq("host_rd_ack_lat", n, 1);
        check_eq("host_rd_port", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, a});
        host_req = 1'b0;
        wait_sig(3, n);
        check_eq("host_rd_lat", n, 1);
        check_eq("host_rd_data", {tx_valid, host_rdata}, {1'b0, m_mem[a]});
        tick();
        check_eq("host_rd_hold", {host_rvalid, host_rdata}, {1'b0, m_mem[a]});
    endtask

    initial begin
        int n;
        logic [7:0] exp_a;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 10'd0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 8'd0; host_wdata = 8'd0;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'(i * 7 + 3);
            m_mem[i] = 8'(i * 7 + 3);
        end
        m_wr = 8'd0; m_rd = 8'd0;
        repeat (3) tick();
        check_eq("reset_outs", all_outs(), 64'd0);
        rst = 1'b0;

        // 1/2: SPI write then read back at 0x10
        spi_addr(CMD_WR_ADDR, 8'h10);
        spi_write(8'hA5);
        spi_addr(CMD_RD_ADDR, 8'h10);
        spi_read();
        check_eq("t2_mem", mem[8'h10], 8'hA5);

        // 3: host read ties with an SPI data frame; host wins
        spi_addr(CMD_WR_ADDR, 8'h30);
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        send(CMD_WR_DATA, 8'h3C);
        tick();
        check_eq("t3_ack", {host_ack, ram_en, ram_we, ram_addr}, {1'b1, 1'b1, 1'b0, 8'h20});
        host_req = 1'b0;
        tick();
        check_eq("t3_rvalid", {host_rvalid, host_rdata, tx_valid}, {1'b1, m_mem[8'h20], 1'b0});
        wait_sig(0, n);
        check_eq("t3_spi_lat", n, 2);
        check_eq("t3_spi_port", {ram_addr, ram_wdata}, {m_wr, 8'h3C});
        m_mem[m_wr] = 8'h3C;
        bump_wr();
        tick();
        check_eq("t3_no_ovf", spi_ovf, 1'b0);

        // Random transaction mix
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 5))
                0:       spi_addr(CMD_WR_ADDR, 8'($urandom_range(0, 15)));
                1:       spi_addr(CMD_RD_ADDR, 8'($urandom_range(0, 15)));
                2:       spi_write(8'($urandom));
                3:       spi_read();
                4:       host_write(8'($urandom_range(0, 15)), 8'($urandom));
                default: host_read(8'($urandom_range(0, 15)));
            endcase
        end
        check_eq("rand_no_ovf", spi_ovf, 1'b0);

        // 4: two data frames while a host read is in flight
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h44;
        tick();
        check_eq("t4_ack", host_ack, 1'b1);
        host_req = 1'b0;
        send(CMD_WR_DATA, 8'h11);
        tick();
        check_eq("t4_rvalid", {host_rvalid, host_rdata}, {1'b1, m_mem[8'h44]});
        send(CMD_WR_DATA, 8'h22);
        tick();
        check_eq("t4_ovf_set", spi_ovf, 1'b1);
        wait_sig(0, n);
        check_eq("t4_wr_lat", n, 1);
        check_eq("t4_wr_port", {ram_addr, ram_wdata}, {m_wr, 8'h11});
        m_mem[m_wr] = 8'h11;
        bump_wr();
        n = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ram_en) n++;
        end
        check_eq("t4_no_second_wr", n, 0);
        host_read(8'h05);
        check_eq("t4_ovf_sticky", spi_ovf, 1'b1);

        // 5: reset during RESP of a host read
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        tick();
        check_eq("t5_ack", host_ack, 1'b1);
        host_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_eq("t5_no_rvalid", host_rvalid, 1'b0);
        tick();
        rst = 1'b0;
        check_eq("t5_outs_zero", all_outs(), 64'd0);
        m_wr = 8'd0; m_rd = 8'd0;
        spi_write(8'h77);
        spi_read();

        // 6: write address wrap
        spi_addr(CMD_WR_ADDR, 8'hFF);
        spi_write(8'h5A);
`ifdef SPI_ADDR_AUTOINC_EN
        exp_a = 8'h00;
`else
        exp_a = 8'hFF;
`endif
        send(CMD_WR_DATA, 8'hC3);
        wait_sig(0, n);
        check_eq("t6_wrap_addr", {ram_addr, ram_wdata}, {exp_a, 8'hC3});
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
